// File: rtl/pc_branch_unit.sv
// pc_branch_unit: NZP register, next-PC select (SEQ/BRnzp/CALL/RET), return-address stack, taken and sticky fault status
module pc_branch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [2:0]          core_state,
  input  logic [1:0]          pc_mode,
  input  logic [2:0]          nzp_instr,
  input  logic [2:0]          nzp_out,
  input  logic                nzp_write_enable,
  input  logic [PC_WIDTH-1:0] current_pc,
  input  logic [PC_WIDTH-1:0] immediate,
  output logic [2:0]          nzp,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                branch_taken,
  output logic [DEPTH_W-1:0]  stack_count,
  output logic                stack_overflow,
  output logic                stack_underflow
);
  logic [2:0]          nzp_q, nzp_d;
  logic [PC_WIDTH-1:0] next_pc_q, next_pc_d;
  logic                taken_q, taken_d;
  logic [DEPTH_W-1:0]  count_q, count_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic                exec, upd, full, empty, is_call, is_ret, push, pop, redirect;
  logic [PC_WIDTH-1:0] seq, pop_val;
  always_comb begin
    exec     = enable && core_state == 3'b101;
    upd      = enable && core_state == 3'b110;
    seq      = current_pc + PC_WIDTH'(1);
    full     = count_q == DEPTH_W'(STACK_DEPTH);
    empty    = count_q == '0;
    is_call  = exec && pc_mode == 2'b10;
    is_ret   = exec && pc_mode == 2'b11;
    push     = is_call && !full;
    pop      = is_ret && !empty;
    redirect = push || pop || (exec && pc_mode == 2'b01 && |(nzp_q & nzp_instr));
    pop_val  = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      stack_d[i] = push && count_q == DEPTH_W'(i) ? seq : stack_q[i];
      pop_val    = count_q == DEPTH_W'(i + 1) ? stack_q[i] : pop_val;
    end
    nzp_d     = upd && nzp_write_enable ? nzp_out : nzp_q;
    next_pc_d = !exec ? next_pc_q : pop ? pop_val : redirect ? immediate : seq;
    taken_d   = exec ? redirect : taken_q;
    count_d   = push ? count_q + DEPTH_W'(1) : pop ? count_q - DEPTH_W'(1) : count_q;
    ovf_d     = ovf_q || (is_call && full);
    unf_d     = unf_q || (is_ret && empty);
  end
  always_ff @(posedge clock) begin
    stack_q <= stack_d;
    if (reset) begin
      nzp_q     <= '0;
      next_pc_q <= '0;
      taken_q   <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      nzp_q     <= nzp_d;
      next_pc_q <= next_pc_d;
      taken_q   <= taken_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end
  assign nzp             = nzp_q;
  assign next_pc         = next_pc_q;
  assign branch_taken    = taken_q;
  assign stack_count     = count_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: random and directed checks of pc_branch_unit against a queue-based model
module tb_pc_branch_unit;
  localparam int PW = 8;
  localparam int SD = 4;
  localparam int DW = $clog2(SD + 1);
  logic clock = 1'b0;
  logic reset, enable, nzp_write_enable;
  logic [2:0] core_state, nzp_instr, nzp_out;
  logic [1:0] pc_mode;
  logic [PW-1:0] current_pc, immediate;
  logic [2:0] nzp;
  logic [PW-1:0] next_pc;
  logic branch_taken, stack_overflow, stack_underflow;
  logic [DW-1:0] stack_count;
  int checks = 0;
  int failures = 0;
  logic [2:0] m_nzp;
  logic [PW-1:0] m_pc;
  logic m_bt, m_ovf, m_unf;
  logic [PW-1:0] m_stack [$];
  pc_branch_unit #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) dut (
    .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
    .pc_mode(pc_mode), .nzp_instr(nzp_instr), .nzp_out(nzp_out),
    .nzp_write_enable(nzp_write_enable), .current_pc(current_pc), .immediate(immediate),
    .nzp(nzp), .next_pc(next_pc), .branch_taken(branch_taken), .stack_count(stack_count),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic model_update();
    logic [PW-1:0] s;
    s = current_pc + 1;
    if (reset) begin
      m_nzp = 0; m_pc = 0; m_bt = 0; m_ovf = 0; m_unf = 0;
      m_stack.delete();
    end else if (enable && core_state == 3'b110) begin
      if (nzp_write_enable) m_nzp = nzp_out;
    end else if (enable && core_state == 3'b101) begin
      case (pc_mode)
        2'd0: begin m_pc = s; m_bt = 0; end
        2'd1: begin m_bt = (m_nzp & nzp_instr) != 0; m_pc = m_bt ? immediate : s; end
        2'd2: if (m_stack.size() < SD) begin
                m_stack.push_back(s); m_pc = immediate; m_bt = 1;
              end else begin
                m_ovf = 1; m_pc = s; m_bt = 0;
              end
        default: if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back(); m_bt = 1;
              end else begin
                m_unf = 1; m_pc = s; m_bt = 0;
              end
      endcase
    end
  endtask
  task automatic tick();
    model_update();
    @(posedge clock);
    #1;
    chk("nzp", 32'(nzp), 32'(m_nzp));
    chk("next_pc", 32'(next_pc), 32'(m_pc));
    chk("branch_taken", 32'(branch_taken), 32'(m_bt));
    chk("stack_count", 32'(stack_count), m_stack.size());
    chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
    chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
  endtask
  task automatic drive(input logic rst, input logic en, input logic [2:0] st, input logic [1:0] md,
                       input logic [2:0] ni, input logic [2:0] no, input logic we,
                       input logic [PW-1:0] cp, input logic [PW-1:0] im);
    reset = rst; enable = en; core_state = st; pc_mode = md; nzp_instr = ni;
    nzp_out = no; nzp_write_enable = we; current_pc = cp; immediate = im;
    tick();
  endtask
  task automatic do_reset();
    drive(1, 1, 3'b101, 2'd2, 0, 0, 0, 0, 0);
  endtask
  task automatic exec(input logic [1:0] md, input logic [2:0] ni, input logic [PW-1:0] cp, input logic [PW-1:0] im);
    drive(0, 1, 3'b101, md, ni, 0, 0, cp, im);
  endtask
  task automatic update(input logic [2:0] no);
    drive(0, 1, 3'b110, 2'd0, 0, no, 1, 0, 0);
  endtask
  initial begin
    do_reset();
    update(3'b111);
    exec(2'd2, 0, 8'd7, 8'd33);
    exec(2'd3, 0, 8'd0, 8'd0);
    exec(2'd3, 0, 8'd0, 8'd0);
    do_reset();
    chk("rst_nzp", 32'(nzp), 0);
    chk("rst_pc", 32'(next_pc), 0);
    chk("rst_cnt", 32'(stack_count), 0);
    chk("rst_bt", 32'(branch_taken), 0);
    chk("rst_flags", {stack_overflow, stack_underflow}, 0);
    update(3'b010);
    chk("nzp_write", 32'(nzp), 3'b010);
    exec(2'd1, 3'b010, 8'd10, 8'd100);
    chk("br_taken_pc", 32'(next_pc), 100);
    chk("br_taken_bt", 32'(branch_taken), 1);
    exec(2'd1, 3'b001, 8'd10, 8'd100);
    chk("br_not_pc", 32'(next_pc), 11);
    chk("br_not_bt", 32'(branch_taken), 0);
    exec(2'd1, 3'b000, 8'd10, 8'd100);
    chk("br_mask0_pc", 32'(next_pc), 11);
    exec(2'd0, 0, 8'hFF, 8'd5);
    chk("seq_wrap", 32'(next_pc), 0);
    exec(2'd2, 0, 8'd10, 8'd50);
    exec(2'd2, 0, 8'd20, 8'd60);
    exec(2'd2, 0, 8'd30, 8'd70);
    chk("call3_cnt", 32'(stack_count), 3);
    chk("call3_pc", 32'(next_pc), 70);
    exec(2'd3, 0, 8'd0, 8'd0);
    chk("ret1", 32'(next_pc), 31);
    exec(2'd3, 0, 8'd0, 8'd0);
    chk("ret2", 32'(next_pc), 21);
    exec(2'd3, 0, 8'd0, 8'd0);
    chk("ret3", 32'(next_pc), 11);
    chk("ret_cnt", 32'(stack_count), 0);
    do_reset();
    for (int i = 1; i <= 5; i++) exec(2'd2, 0, PW'(i), PW'(100 + i));
    chk("ovf_flag", 32'(stack_overflow), 1);
    chk("ovf_pc", 32'(next_pc), 6);
    chk("ovf_cnt", 32'(stack_count), 4);
    exec(2'd3, 0, 8'd0, 8'd0);
    chk("ovf_ret", 32'(next_pc), 5);
    chk("ovf_sticky", 32'(stack_overflow), 1);
    do_reset();
    exec(2'd3, 0, 8'd40, 8'd0);
    chk("unf_flag", 32'(stack_underflow), 1);
    chk("unf_pc", 32'(next_pc), 41);
    drive(0, 0, 3'b101, 2'd2, 0, 0, 0, 8'd90, 8'd9);
    chk("dis_pc", 32'(next_pc), 41);
    chk("dis_cnt", 32'(stack_count), 0);
    drive(0, 1, 3'b011, 2'd2, 0, 0, 0, 8'd90, 8'd9);
    chk("idle_cnt", 32'(stack_count), 0);
    exec(2'd2, 0, 8'd1, 8'd2);
    exec(2'd2, 0, 8'd2, 8'd3);
    chk("pre_rst_cnt", 32'(stack_count), 2);
    do_reset();
    chk("mid_rst_cnt", 32'(stack_count), 0);
    chk("mid_rst_flags", {stack_overflow, stack_underflow}, 0);
    exec(2'd3, 0, 8'd60, 8'd0);
    chk("post_rst_unf", 32'(stack_underflow), 1);
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] st;
      case ($urandom_range(0, 4))
        0, 1: st = 3'b101;
        2, 3: st = 3'b110;
        default: st = 3'($urandom);
      endcase
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, st, 2'($urandom),
            3'($urandom), 3'($urandom), 1'($urandom), PW'($urandom), PW'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
